// File: rtl/axi4_rd_slave_pkg.sv
`timescale 1ns/1ps
// Shared types and address helpers for the AXI4 read responder.
package axi4_rd_slave_pkg;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Fields are sized for the widest supported configuration; the top casts to its own widths.
  localparam int REQ_ID_W   = 16;
  localparam int REQ_ADDR_W = 64;

  typedef struct packed {
    logic [REQ_ID_W-1:0]   id;
    logic [REQ_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_e                burst;
    logic                  err;
  } ar_req_s;

  function automatic logic [REQ_ADDR_W-1:0] next_addr(input logic [REQ_ADDR_W-1:0] addr,
                                                     input logic [2:0] size,
                                                     input logic [7:0] len,
                                                     input burst_e burst);
    logic [REQ_ADDR_W-1:0] step, mask;
    step = REQ_ADDR_W'(1) << size;
    mask = ((REQ_ADDR_W'(len) + REQ_ADDR_W'(1)) << size) - REQ_ADDR_W'(1);
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr + step;
    endcase
  endfunction

  // Whole-burst error: reserved burst type, oversize beat, or malformed wrap.
  function automatic logic req_err(input logic [REQ_ADDR_W-1:0] addr,
                                   input logic [2:0] size,
                                   input logic [7:0] len,
                                   input burst_e burst,
                                   input logic [2:0] max_size);
    logic [REQ_ADDR_W-1:0] step;
    step = REQ_ADDR_W'(1) << size;
    req_err = (burst == RSVD) || (size > max_size) ||
              (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              (burst == WRAP && (addr & (step - REQ_ADDR_W'(1))) != '0);
  endfunction

endpackage

// File: rtl/axi4_rd_slave_ar_fifo.sv
`timescale 1ns/1ps
// axi4_ar_fifo: 2-entry AR request queue; the producer must not push while full.
module axi4_ar_fifo
  import axi4_rd_slave_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  ar_req_s din,
  input  logic    pop,
  output ar_req_s dout,
  output logic    valid,
  output logic    full
);
  ar_req_s    slot [2];
  logic       wp, rp;
  logic [1:0] cnt;

  assign dout  = slot[rp];
  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);

  always_ff @(posedge clk)
    if (push) slot[wp] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= !wp;
      if (pop)  rp <= !rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/axi4_rd_slave.sv
`timescale 1ns/1ps
// axi4_rd_slave: AXI4 read responder over an internal word memory (FIXED/INCR/WRAP, SLVERR on bad requests).
// Define AXI4_RD_SLAVE_ARQ_EN to add a 2-entry AR queue so back-to-back bursts have no bubble.
module axi4_rd_slave
  import axi4_rd_slave_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ID_W-1:0]              arid,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_W-1:0]              rid,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]            mem_wdata
);
  localparam int         SHIFT    = $clog2(DATA_W / 8);
  localparam int         MAW      = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(SHIFT);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state;
  ar_req_s           cur, in_req, src, load_req;
  logic [ADDR_W-1:0] load_addr, idx;
  logic [7:0]        cnt, load_cnt;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              ar_hs, r_hs, free, start, bad;

  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;

  always_comb begin
    in_req       = '0;
    in_req.id    = REQ_ID_W'(arid);
    in_req.addr  = REQ_ADDR_W'(araddr);
    in_req.len   = arlen;
    in_req.size  = arsize;
    in_req.burst = burst_e'(arburst);
    in_req.err   = req_err(REQ_ADDR_W'(araddr), arsize, arlen, burst_e'(arburst), MAX_SIZE);
  end

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  // The engine can take a new request in IDLE or on the edge that retires the last beat.
  assign free  = (state == IDLE) || (r_hs && rlast);

`ifdef AXI4_RD_SLAVE_ARQ_EN
  ar_req_s q_head;
  logic    q_valid, q_full, q_push, q_pop, rdy;

  // An arriving request bypasses the queue when it is empty and the engine is free.
  assign start   = free && (q_valid || ar_hs);
  assign src     = q_valid ? q_head : in_req;
  assign q_pop   = free && q_valid;
  assign q_push  = ar_hs && !(free && !q_valid);
  assign arready = rdy && !q_full;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= 1'b1;

  axi4_ar_fifo u_arq (
    .clk(clk), .rst_n(rst_n), .push(q_push), .din(in_req),
    .pop(q_pop), .dout(q_head), .valid(q_valid), .full(q_full)
  );
`else
  assign start = free && ar_hs;
  assign src   = in_req;
`endif

  // Either the first beat of a new burst or the successor of the current beat.
  always_comb begin
    if (start) begin
      load_req  = src;
      load_addr = ADDR_W'(src.addr);
      load_cnt  = 8'd0;
    end else begin
      load_req  = cur;
      load_addr = ADDR_W'(next_addr(cur.addr, cur.size, cur.len, cur.burst));
      load_cnt  = cnt + 8'd1;
    end
  end

  assign idx = load_addr >> SHIFT;
  assign bad = load_req.err || (idx >= ADDR_W'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur    <= '0;
      cnt    <= 8'd0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      rlast  <= 1'b0;
      rid    <= '0;
`ifndef AXI4_RD_SLAVE_ARQ_EN
      arready <= 1'b0;
`endif
    end else begin
      if (start || (r_hs && !rlast)) begin
        state    <= BURST;
        cur      <= load_req;
        cur.addr <= REQ_ADDR_W'(load_addr);
        cnt      <= load_cnt;
        rvalid   <= 1'b1;
        rdata    <= bad ? '0 : mem[MAW'(idx)];
        rresp    <= bad ? RESP_SLVERR : RESP_OKAY;
        rlast    <= (load_cnt == load_req.len);
        rid      <= ID_W'(load_req.id);
      end else if (r_hs) begin
        state  <= IDLE;
        rvalid <= 1'b0;
      end
`ifndef AXI4_RD_SLAVE_ARQ_EN
      arready <= (state == IDLE) ? !ar_hs : (r_hs && rlast);
`endif
    end
  end
endmodule

// File: tb/tb_axi4_rd_slave.sv
`timescale 1ns/1ps
// Self-checking bench for axi4_rd_slave: directed table, corner sequences, randomized bursts vs a reference model.
module tb_axi4_rd_slave;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_DEPTH = 1024;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [ID_W-1:0]   arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              arvalid = 1'b0, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid;
  logic              rready = 1'b0;
  logic              mem_we = 1'b0;
  logic [9:0]        mem_waddr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;

  axi4_rd_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [MEM_DEPTH];
  int checks = 0, errors = 0;

  typedef struct {logic [31:0] d; logic [1:0] r; logic l; bit bad;} beat_t;

  typedef struct {
    logic [3:0] id; logic [31:0] a; int len; int size; int burst; bit stall;
    int n_exp; logic [31:0] d0; logic [1:0] r0; logic [31:0] dl; logic [1:0] rl; bit chk_d;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: burst legality and beat addresses straight from the AXI rules.
  function automatic bit req_bad(input logic [31:0] a, input int len, input int size, input int burst);
    longint ua, step;
    ua = a;
    step = longint'(1) << size;
    if (burst == 3 || size > 2) return 1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1;
    if (burst == 2 && (ua % step) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                           input int burst, input int i);
    longint ua, step, bytes, base;
    ua = a;
    step = longint'(1) << size;
    if (burst == 0) return a;
    if (burst == 2) begin
      bytes = (len + 1) * step;
      base  = (ua / bytes) * bytes;
      return 32'(base + ((ua - base) + i * step) % bytes);
    end
    return 32'(ua + i * step);
  endfunction

  function automatic beat_t exp_beat(input logic [31:0] a, input int len, input int size,
                                     input int burst, input int i);
    beat_t b;
    logic [31:0] ba;
    b.bad = req_bad(a, len, size, burst);
    b.l   = (i == len);
    ba    = beat_addr(a, len, size, burst, i);
    if (b.bad || (ba >> 2) >= MEM_DEPTH) begin b.r = 2'b10; b.d = '0; end
    else begin b.r = 2'b00; b.d = ref_mem[ba >> 2]; end
    return b;
  endfunction

  task automatic bd_write(input int k, input logic [31:0] d);
    mem_we = 1'b1; mem_waddr = 10'(k); mem_wdata = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
    ref_mem[k] = d;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input int len, input int size,
                         input int burst);
    @(posedge clk); #1;
    arid = id; araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1;
        arvalid = 1'b0;
        return;
      end
    end
    arvalid = 1'b0;
    checks++; errors++;
    $display("FAIL ar_timeout actual=no_arready required=arready");
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] a, input int len, input int size,
                           input int burst, input bit stall, input int rdy_pct,
                           output beat_t first, output beat_t last, output int n);
    beat_t e;
    int i = 0, stalls = 0;
    bit rr;
    n = 0;
    first = '{default: '0}; last = '{default: '0};
    send_ar(id, a, len, size, burst);
    for (int cyc = 0; cyc < 400 && i <= len; cyc++) begin
      @(negedge clk);
      chk("rvalid_in_burst", 64'(rvalid), 64'd1);
      if (!rvalid) continue;
      e = exp_beat(a, len, size, burst, i);
      chk("beat", {rid, rresp, rlast, (e.bad ? e.d : rdata)}, {id, e.r, e.l, e.d});
      if (stall && i == 1 && stalls < 3) begin rr = 1'b0; stalls++; end
      else rr = ($urandom_range(99) < rdy_pct);
      rready = rr;
      if (rr) begin
        if (i == 0) first = '{rdata, rresp, rlast, 1'b0};
        last = '{rdata, rresp, rlast, 1'b0};
        i++; n++;
      end
    end
    if (i <= len) begin
      checks++; errors++;
      $display("FAIL r_timeout actual=%0d beats required=%0d", i, len + 1);
    end
  endtask

  vec_t  vt[8];
  beat_t f, l, q[$];
  logic [3:0] qid[$];
  int    n, gaps, exp_gap;
  bit    sent, started;

  initial begin
    vt[0] = '{4'd5, 32'h0,    3, 2, 1, 1'b0, 4, 32'h100,    2'b00, 32'h103, 2'b00, 1'b1};
    vt[1] = '{4'd1, 32'h8,    3, 2, 2, 1'b0, 4, 32'h102,    2'b00, 32'h101, 2'b00, 1'b1};
    vt[2] = '{4'd2, 32'h8,    2, 2, 2, 1'b0, 3, 32'h0,      2'b10, 32'h0,   2'b10, 1'b0};
    vt[3] = '{4'd3, 32'h4,    2, 2, 0, 1'b1, 3, 32'h101,    2'b00, 32'h101, 2'b00, 1'b1};
    vt[4] = '{4'd4, 32'hFFC,  1, 2, 1, 1'b0, 2, 32'h0000D00D, 2'b00, 32'h0, 2'b10, 1'b1};
    vt[5] = '{4'd6, 32'h0,    1, 2, 3, 1'b0, 2, 32'h0,      2'b10, 32'h0,   2'b10, 1'b0};
    vt[6] = '{4'd7, 32'h0,    0, 3, 1, 1'b0, 1, 32'h0,      2'b10, 32'h0,   2'b10, 1'b0};
    vt[7] = '{4'd9, 32'h6,    1, 2, 2, 1'b0, 2, 32'h0,      2'b10, 32'h0,   2'b10, 1'b0};

    #12;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_outputs", {rvalid, rlast, rid, rdata, rresp}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_rst", 64'(arready), 64'd1);

    for (int k = 0; k < MEM_DEPTH; k++)
      bd_write(k, (k < 8) ? 32'h100 + 32'(k) : (k == MEM_DEPTH - 1) ? 32'h0000D00D : $urandom);

    foreach (vt[v]) begin
      run_burst(vt[v].id, vt[v].a, vt[v].len, vt[v].size, vt[v].burst, vt[v].stall, 100, f, l, n);
      chk($sformatf("vec%0d_beats", v), 64'(n), 64'(vt[v].n_exp));
      chk($sformatf("vec%0d_resp", v), {f.r, l.r, l.l}, {vt[v].r0, vt[v].rl, 1'b1});
      if (vt[v].chk_d) chk($sformatf("vec%0d_data", v), {f.d, l.d}, {vt[v].d0, vt[v].dl});
    end

    // Two requests with arvalid held: count empty R cycles between the bursts.
`ifdef AXI4_RD_SLAVE_ARQ_EN
    exp_gap = 0;
`else
    exp_gap = 1;
`endif
    for (int i = 0; i < 2; i++) begin q.push_back(exp_beat(32'h10, 1, 2, 1, i)); qid.push_back(4'd1); end
    for (int i = 0; i < 2; i++) begin q.push_back(exp_beat(32'h20, 1, 2, 1, i)); qid.push_back(4'd2); end
    @(posedge clk); #1;
    arid = 4'd1; araddr = 32'h10; arlen = 8'd1; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1; rready = 1'b1;
    sent = 0; started = 0; gaps = 0;
    for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
      @(negedge clk);
      if (rvalid) begin
        chk("b2b_beat", {rid, rresp, rlast, rdata}, {qid[0], q[0].r, q[0].l, q[0].d});
        void'(q.pop_front()); void'(qid.pop_front());
        started = 1;
      end else if (started) gaps++;
      if (arvalid && arready) begin
        @(posedge clk); #1;
        if (!sent) begin arid = 4'd2; araddr = 32'h20; sent = 1; end
        else arvalid = 1'b0;
      end
    end
    arvalid = 1'b0;
    chk("b2b_left", 64'(q.size()), 64'd0);
    chk("b2b_gap", 64'(gaps), 64'(exp_gap));

    // Reset during beat 1 of a 4-beat burst.
    rready = 1'b1;
    send_ar(4'd3, 32'h0, 3, 2, 1);
    @(negedge clk);
    chk("rstmid_beat0", {rresp, rdata}, {2'b00, ref_mem[0]});
    @(negedge clk);
    rready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_rvalid", {rvalid, arready}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_arready", 64'(arready), 64'd1);
    run_burst(4'd5, 32'h0, 3, 2, 1, 1'b0, 100, f, l, n);
    chk("rstmid_after", {64'(n), f.d, l.d}, {64'd4, 32'h100, 32'h103});

    for (int t = 0; t < 40; t++) begin
      int len, size, burst;
      logic [31:0] a;
      if (t % 5 == 0) bd_write($urandom_range(0, 15), $urandom);
      burst = $urandom_range(0, 3);
      size  = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
      len   = (burst == 2 && $urandom_range(0, 1)) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      a     = 32'($urandom_range(0, 4200));
      if (burst == 2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 1);
      run_burst(4'($urandom), a, len, size, burst, 1'b0, 75, f, l, n);
      chk("rand_beats", 64'(n), 64'(len + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
